// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa_bh.sv
// ============================================================================
// Module      : fa_bh
// Description : 1-bit full adder built from two half-adder cells and an OR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_bh (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // first half adder: A + B; second half adder: partial sum + CIN
  assign w_s1 = A ^ B;
  assign w_c1 = A & B;
  assign SUM  = w_s1 ^ CIN;
  assign w_c2 = w_s1 & CIN;
  assign COUT = w_c1 | w_c2;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtracter, LSB-first through one full adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);

  localparam int                c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_areg;
  logic [WIDTH-1:0]   r_breg;
  logic [WIDTH-1:0]   r_sreg;
  logic [WIDTH-1:0]   r_sum;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_cflop;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;

  logic               w_s;
  logic               w_co;
  logic [WIDTH-1:0]   w_snext;

  fa_bh u_fa (
    .A    (r_areg[0]),
    .B    (r_breg[0]),
    .CIN  (r_cflop),
    .SUM  (w_s),
    .COUT (w_co)
  );

  assign w_snext = {w_s, r_sreg[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= IDLE;
      r_areg  <= '0;
      r_breg  <= '0;
      r_sreg  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cflop <= 1'b0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            // subtraction is A + ~B + 1: invert B and seed the carry with SUB
            r_areg  <= A;
            r_breg  <= B ^ {WIDTH{SUB}};
            r_cflop <= SUB;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_sreg  <= w_snext;
          r_areg  <= r_areg >> 1;
          r_breg  <= r_breg >> 1;
          r_cflop <= w_co;
          r_cnt   <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last) begin
            r_sum   <= w_snext;
            r_carry <= w_co;
            r_state <= FINISH;
            r_done  <= 1'b1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign SUM   = r_sum;
  assign CARRY = r_carry;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             CLR_N = 1'b0;
  logic             START = 1'b0;
  logic             SUB = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [WIDTH-1:0] SUM;
  logic             CARRY;
  logic             BUSY;
  logic             DONE;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .SUM   (SUM),
    .CARRY (CARRY),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a result is the plain (WIDTH+1)-bit sum A + B' + SUB, published
  // WIDTH edges after acceptance; the block stays busy for WIDTH+1 cycles.
  int             m_rem;
  logic [WIDTH:0] m_pend;
  logic [WIDTH-1:0] m_sum;
  logic           m_carry;

  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      m_rem   <= 0;
      m_pend  <= '0;
      m_sum   <= '0;
      m_carry <= 1'b0;
    end else if (m_rem == 0) begin
      if (START) begin
        m_rem  <= WIDTH + 1;
        m_pend <= {1'b0, A} + {1'b0, (SUB ? ~B : B)} + (WIDTH+1)'(SUB);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) {m_carry, m_sum} <= m_pend;
    end
  end

  always @(negedge CLK) begin
    chk("model_sum",   32'(SUM),   32'(m_sum));
    chk("model_carry", 32'(CARRY), 32'(m_carry));
    chk("model_busy",  32'(BUSY),  32'(m_rem > 0));
    chk("model_done",  32'(DONE),  32'(m_rem == 1));
  end

  // Starts one operation and waits for DONE, returning busy cycles seen.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, output int busy_cnt, output bit got);
    A = a; B = b; SUB = sub; START = 1'b1;
    busy_cnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (BUSY) busy_cnt++;
      if (DONE) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int  nb;
    bit  got;
    int  ndone;
    int  t1, t2, cyc;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_sum",   32'(SUM),   32'h0);
    chk("rst_carry", 32'(CARRY), 32'h0);
    chk("rst_busy",  32'(BUSY),  32'h0);
    chk("rst_done",  32'(DONE),  32'h0);
    #2 CLR_N = 1'b1;
    @(negedge CLK);

    // plain add with latency
    run_op(8'h3C, 8'h0F, 1'b0, nb, got);
    chk("add_sum",   32'(SUM),   32'h4B);
    chk("add_carry", 32'(CARRY), 32'h0);
    chk("add_busy_cycles", 32'(nb), 32'd9);
    @(negedge CLK);

    // carry out and borrow
    run_op(8'hFF, 8'h01, 1'b0, nb, got);
    chk("cout_sum",   32'(SUM),   32'h00);
    chk("cout_carry", 32'(CARRY), 32'h1);
    @(negedge CLK);
    run_op(8'h01, 8'h02, 1'b1, nb, got);
    chk("borrow_sum",   32'(SUM),   32'hFF);
    chk("borrow_carry", 32'(CARRY), 32'h0);
    @(negedge CLK);

    // subtract with operand change and START pulse mid-operation
    A = 8'h10; B = 8'h01; SUB = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    A = 8'hAA; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ndone = 0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("sub_done_count", 32'(ndone), 32'd1);
    chk("sub_sum",   32'(SUM),   32'h0F);
    chk("sub_carry", 32'(CARRY), 32'h1);

    // reset after the 4th shift aborts the operation
    A = 8'h3C; B = 8'h0F; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #2 CLR_N = 1'b0;
    #1;
    chk("abort_sum",   32'(SUM),   32'h00);
    chk("abort_carry", 32'(CARRY), 32'h0);
    chk("abort_busy",  32'(BUSY),  32'h0);
    chk("abort_done",  32'(DONE),  32'h0);
    @(negedge CLK);
    #2 CLR_N = 1'b1;
    ndone = 0;
    repeat (WIDTH + 2) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'h3C, 8'h0F, 1'b0, nb, got);
    chk("rerun_sum", 32'(SUM), 32'h4B);
    @(negedge CLK);

    // back-to-back with START held high
    A = 8'h01; B = 8'h01; SUB = 1'b0; START = 1'b1;
    t1 = -1; t2 = -1; cyc = 0;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(negedge CLK);
      cyc++;
      if (DONE && t1 < 0) begin
        t1 = cyc;
        chk("b2b_sum1",   32'(SUM),   32'h02);
        chk("b2b_carry1", 32'(CARRY), 32'h0);
        A = 8'h80; B = 8'h80;
      end else if (DONE) begin
        t2 = cyc;
        START = 1'b0;
      end else if (t1 >= 0 && BUSY) begin
        chk("b2b_hold", 32'(SUM), 32'h02);
      end
    end
    START = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'd10);
    chk("b2b_sum2",   32'(SUM),   32'h00);
    chk("b2b_carry2", 32'(CARRY), 32'h1);
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder-subtracter for the SAP datapath. It captures two WIDTH-bit operands and shifts them LSB-first through a single full-adder cell, one bit per clock. A carry flip-flop holds the carry between bits, and a result register delivers the final SUM and CARRY. It sits directly downstream of the single-bit adder cells and is the sequential consumer of their SUM/CARRY outputs. It trades latency for one adder cell instead of a WIDTH-bit ripple chain.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- START  in  1  request a new operation; sampled only in IDLE.
- SUB  in  1  0 = A+B, 1 = A−B (two's complement); captured with START.
- A  in  WIDTH  operand A; captured with START.
- B  in  WIDTH  operand B; captured with START.
- SUM  out  WIDTH  registered result; holds until the next completion.
- CARRY  out  1  registered final carry-out; in SUB mode 1 = no borrow (A ≥ B).
- BUSY  out  1  high whenever the FSM is not in IDLE.
- DONE  out  1  one-cycle pulse; SUM/CARRY are valid and newly updated.

## Operation
- FSM states: IDLE, SHIFT, FINISH. Encoded as a typed enum; BUSY = (state != IDLE); DONE = (state == FINISH).
- IDLE, with START=1 at an edge:
  - areg ← A; breg ← B XOR {WIDTH{SUB}}.
  - carry flop ← SUB; bit counter ← 0; state → SHIFT.
- SHIFT, each edge:
  - Full-add areg[0], breg[0] and the carry flop, giving s and co.
  - sreg ← {s, sreg[WIDTH-1:1]}; areg, breg shift right by one; carry flop ← co; counter++.
  - On the edge where counter == WIDTH−1: SUM ← {s, sreg[WIDTH-1:1]}, CARRY ← co, state → FINISH.
- FINISH: state → IDLE on the next edge unconditionally.
- START is ignored in SHIFT and FINISH; no queuing.
- A, B and SUB changes after capture have no effect on the operation in flight.
- Arithmetic is modulo 2^WIDTH; CARRY is the true carry-out of bit WIDTH−1.
- No overflow flag.

## Timing
- Reset (CLR_N low, asynchronous):
  - state = IDLE; SUM = 0; CARRY = 0; BUSY = 0; DONE = 0.
  - areg, breg, sreg, counter and carry flop are cleared.
- Reset mid-operation aborts the operation. SUM/CARRY read 0, not the previous result.
- Release of CLR_N is synchronous to CLK. The first START is honoured on the first edge after release.
- Latency, START accepted at edge k:
  - BUSY rises after edge k.
  - Shifts occur on edges k+1 … k+WIDTH.
  - SUM/CARRY update and DONE rises after edge k+WIDTH.
  - DONE and BUSY fall after edge k+WIDTH+1.
- With START held high, a new operation is accepted every WIDTH+2 cycles (first accept in IDLE at edge k+WIDTH+2).
- During SHIFT, SUM/CARRY continue to show the previous result; partial sums are never visible.

## Structure
- Package serial_adder_pkg: state enum typedef (IDLE, SHIFT, FINISH) and the default width constant.
- Counter width is $clog2(WIDTH).
- One sub-module: fa_bh, a 1-bit full adder (A, B, CIN → SUM, COUT) composed from two half-adder cells plus an OR. Instantiated once in the datapath.
- Everything else (registers, FSM) lives in serial_adder.

## Test plan
- Add, WIDTH=8: A=0x3C, B=0x0F, SUB=0, START at edge k -> DONE pulse after edge k+8; SUM=0x4B, CARRY=0; BUSY high exactly 9 cycles.
- Carry out: A=0xFF, B=0x01, SUB=0 -> SUM=0x00, CARRY=1. Then A=0x01, B=0x02, SUB=1 -> SUM=0xFF, CARRY=0 (borrow).
- Subtract, no borrow: A=0x10, B=0x01, SUB=1 -> SUM=0x0F, CARRY=1. Changing A to 0xAA and pulsing START during SHIFT -> result unchanged and exactly one DONE.
- Reset mid-op: CLR_N low for 1 cycle after the 4th shift -> SUM=0x00, CARRY=0, BUSY=0 immediately with no DONE. A fresh START with 0x3C+0x0F -> 0x4B after 8 shifts.
- Back-to-back: START held high with operands (0x01,0x01) then (0x80,0x80) -> DONE pulses 10 cycles apart; results 0x02/C=0 and 0x00/C=1. SUM holds 0x02 throughout the second operation's SHIFT phase.
